// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and log record sizing for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  localparam int unsigned LOG_REC_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DUMMY,
    ST_STREAM,
    ST_ID,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  // First state entered after an opcode byte.
  function automatic state_t dispatch_op(input logic [7:0] op);
    case (op)
      OP_READ, OP_FAST_READ: return ST_ADDR;
      OP_RDID:               return ST_ID;
      OP_RDSR:               return ST_STATUS;
      default:               return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_log_serializer.sv
// Turns a 32-bit command record into LOG_REC_BYTES byte strobes, MSB first.
// A record offered while the sink is not ready, while another record is
// draining, or whose value is all zero is discarded whole.
module spi_log_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_valid,
  input  logic [31:0] rec_data,
  input  logic        log_ready,
  output logic [7:0]  log_data,
  output logic        log_strobe
);
  import spi_flash_pkg::*;

  localparam logic [1:0] LAST_LEFT = 2'(LOG_REC_BYTES - 1);

  logic [23:0] rest;
  logic [1:0]  left;

  // Accept a record, then emit one byte per cycle whenever the sink is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      log_data   <= '0;
      log_strobe <= 1'b0;
      rest       <= '0;
      left       <= '0;
    end else begin
      log_strobe <= 1'b0;
      if (left != 2'd0) begin
        if (log_ready) begin
          log_strobe <= 1'b1;
          log_data   <= rest[23:16];
          rest       <= {rest[15:0], 8'h00};
          left       <= left - 2'd1;
        end
      end else if (rec_valid && log_ready && (rec_data != '0)) begin
        log_strobe <= 1'b1;
        log_data   <= rec_data[31:24];
        rest       <= rec_data[23:0];
        left       <= LAST_LEFT;
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-NOR flash protocol engine: decodes opcodes from spi_device byte strobes,
// fetches read data from SDRAM, supplies the next MISO byte and holds SDRAM
// ownership (critical) for the duration of a transaction.
// Optional command logging is enabled by defining SPI_RESPONDER_LOG_EN.
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS = 25,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_strobe,
  input  logic                 rx_cmd,
  input  logic [7:0]           rx_data,
  input  logic                 cs_n,
  output logic [7:0]           tx_data,
  output logic                 critical,
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic                 sd_enable,
  input  logic                 sd_busy,
  input  logic [7:0]           sd_rd_data,
  input  logic                 sd_rd_ready,
  output logic [7:0]           log_data,
  output logic                 log_strobe,
  input  logic                 log_ready
);
  import spi_flash_pkg::*;

  state_t      state;
  state_t      state_next;
  logic [7:0]  opcode;
  logic [1:0]  addr_cnt;
  logic [15:0] addr_hi;
  logic [1:0]  id_idx;
  logic        rd_pending;

  logic        cmd_strobe;
  logic        byte_strobe;
  logic        addr_done;
  logic        rd_request;
  logic [23:0] addr_rx;
  logic [23:0] addr_next;

  assign cmd_strobe  = rx_strobe & rx_cmd & ~cs_n;
  assign byte_strobe = rx_strobe & ~rx_cmd & ~cs_n;
  assign addr_done   = byte_strobe && (state == ST_ADDR) && (addr_cnt == 2'd2);
  assign rd_request  = addr_done || (byte_strobe && (state == ST_STREAM));
  assign addr_rx     = {addr_hi, rx_data};
  assign addr_next   = sd_addr[23:0] + 24'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: deselect wins, then opcode dispatch, then byte-driven advance.
  always_comb begin
    state_next = state;
    if (cs_n) begin
      state_next = ST_IDLE;
    end else if (cmd_strobe) begin
      state_next = dispatch_op(rx_data);
    end else if (byte_strobe) begin
      case (state)
        ST_ADDR: begin
          if (addr_cnt == 2'd2) begin
            state_next = (opcode == OP_FAST_READ) ? ST_DUMMY : ST_STREAM;
          end
        end
        ST_DUMMY: state_next = ST_STREAM;
        default:  state_next = state;
      endcase
    end
  end

  // Registered datapath: MISO byte, SDRAM ownership, address and read issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data    <= 8'hFF;
      critical   <= 1'b0;
      sd_addr    <= '0;
      sd_enable  <= 1'b0;
      rd_pending <= 1'b0;
      opcode     <= '0;
      addr_cnt   <= '0;
      addr_hi    <= '0;
      id_idx     <= '0;
    end else if (cs_n) begin
      tx_data    <= 8'hFF;
      critical   <= 1'b0;
      sd_enable  <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      sd_enable <= 1'b0;

      if (sd_rd_ready && critical) begin
        tx_data <= sd_rd_data;
      end
      if (state == ST_STATUS) begin
        tx_data <= 8'h00;
      end
      if (state == ST_IGNORE) begin
        tx_data <= 8'hFF;
      end

      if (cmd_strobe) begin
        opcode   <= rx_data;
        critical <= 1'b1;
        addr_cnt <= '0;
        case (rx_data)
          OP_RDID: begin
            tx_data <= JEDEC_ID[23:16];
            id_idx  <= 2'd1;
          end
          OP_RDSR: tx_data <= 8'h00;
          default: tx_data <= 8'hFF;
        endcase
      end else if (byte_strobe) begin
        case (state)
          ST_ADDR: begin
            addr_hi  <= {addr_hi[7:0], rx_data};
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2) begin
              sd_addr <= ADDR_BITS'(addr_rx);
            end
          end
          ST_STREAM: sd_addr <= ADDR_BITS'(addr_next);
          ST_ID: begin
            case (id_idx)
              2'd1: begin
                tx_data <= JEDEC_ID[15:8];
                id_idx  <= 2'd2;
              end
              2'd2: begin
                tx_data <= JEDEC_ID[7:0];
                id_idx  <= 2'd3;
              end
              default: tx_data <= 8'h00;
            endcase
          end
          default: ;
        endcase
      end

      // A request that cannot go out this cycle (busy, or a pulse just issued)
      // is parked in rd_pending; a new opcode discards any parked request.
      if (cmd_strobe) begin
        rd_pending <= 1'b0;
      end else if (rd_request || rd_pending) begin
        if (!sd_busy && !sd_enable) begin
          sd_enable  <= 1'b1;
          rd_pending <= 1'b0;
        end else begin
          rd_pending <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_RESPONDER_LOG_EN
  logic        rec_valid;
  logic [31:0] rec_data;

  // Record source: address opcodes log on their third address byte, all others on the opcode.
  always_comb begin
    rec_valid = 1'b0;
    rec_data  = '0;
    if (cmd_strobe && (rx_data != OP_READ) && (rx_data != OP_FAST_READ)) begin
      rec_valid = 1'b1;
      rec_data  = {rx_data, 24'h000000};
    end else if (addr_done) begin
      rec_valid = 1'b1;
      rec_data  = {opcode, addr_rx};
    end
  end

  spi_log_serializer u_log (
    .clk        (clk),
    .reset      (reset),
    .rec_valid  (rec_valid),
    .rec_data   (rec_data),
    .log_ready  (log_ready),
    .log_data   (log_data),
    .log_strobe (log_strobe)
  );
`else
  logic unused_log_ready;
  assign unused_log_ready = log_ready;
  assign log_data         = '0;
  assign log_strobe       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder with a 4-cycle SDRAM model.
module tb_spi_flash_responder;

  localparam int unsigned ADDR_BITS = 25;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rx_strobe = 1'b0;
  logic                 rx_cmd = 1'b0;
  logic [7:0]           rx_data = '0;
  logic                 cs_n = 1'b1;
  logic [7:0]           tx_data;
  logic                 critical;
  logic [ADDR_BITS-1:0] sd_addr;
  logic                 sd_enable;
  logic                 sd_busy = 1'b0;
  logic [7:0]           sd_rd_data = '0;
  logic                 sd_rd_ready = 1'b0;
  logic [7:0]           log_data;
  logic                 log_strobe;
  logic                 log_ready = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  // SDRAM model / monitor state
  logic [ADDR_BITS-1:0] en_q[$];
  int                   en_cyc_q[$];
  int                   due_q[$];
  logic [7:0]           dat_q[$];
  logic [7:0]           log_q[$];
  int                   cyc = 0;
  int                   viol = 0;
  logic                 prev_en = 1'b0;
  logic                 model_quiet = 1'b0;

  spi_flash_responder #(
    .ADDR_BITS (ADDR_BITS),
    .JEDEC_ID  (24'hEF4018)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_strobe   (rx_strobe),
    .rx_cmd      (rx_cmd),
    .rx_data     (rx_data),
    .cs_n        (cs_n),
    .tx_data     (tx_data),
    .critical    (critical),
    .sd_addr     (sd_addr),
    .sd_enable   (sd_enable),
    .sd_busy     (sd_busy),
    .sd_rd_data  (sd_rd_data),
    .sd_rd_ready (sd_rd_ready),
    .log_data    (log_data),
    .log_strobe  (log_strobe),
    .log_ready   (log_ready)
  );

  always #5 clk = ~clk;

  // SDRAM model: data = addr[7:0] + 0x11, returned 4 cycles after sd_enable.
  initial begin : sdram_model
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!model_quiet) sd_rd_ready = 1'b0;
      if (sd_enable === 1'b1) begin
        if (sd_busy) viol++;
        if (prev_en) viol++;
        en_q.push_back(sd_addr);
        en_cyc_q.push_back(cyc);
        due_q.push_back(cyc + 4);
        dat_q.push_back(sd_addr[7:0] + 8'h11);
      end
      prev_en = (sd_enable === 1'b1);
      if (log_strobe === 1'b1) log_q.push_back(log_data);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (!model_quiet) begin
          sd_rd_ready = 1'b1;
          sd_rd_data  = dat_q[0];
        end
        due_q.delete(0);
        dat_q.delete(0);
      end
    end
  end

  task automatic send(input logic cmd, input logic [7:0] b);
    @(negedge clk);
    rx_strobe = 1'b1;
    rx_cmd    = cmd;
    rx_data   = b;
    @(negedge clk);
    rx_strobe = 1'b0;
    rx_cmd    = 1'b0;
  endtask

  task automatic deselect(input int n);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL reset_tx tx_data=%h exp=%h", tx_data, 8'hFF); end
    tests_run++; if (critical !== 1'b0) begin tests_failed++; $display("FAIL reset_critical got=%b exp=0", critical); end
    tests_run++; if (sd_addr !== 25'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", sd_addr); end
    tests_run++; if (sd_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_enable got=%b exp=0", sd_enable); end
    tests_run++; if (log_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_log_strobe got=%b exp=0", log_strobe); end
    tests_run++; if (log_data !== 8'h00) begin tests_failed++; $display("FAIL reset_log_data got=%h exp=00", log_data); end
  endtask

  task automatic test_read;
    int base;
    int crit_low;
    logic [7:0] exp_tx [3];
    logic [ADDR_BITS-1:0] exp_addr [3];
    exp_tx   = '{8'h67, 8'h68, 8'h69};
    exp_addr = '{25'h0123456, 25'h0123457, 25'h0123458};
    base = en_q.size();
    crit_low = 0;
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    tests_run++; if (critical !== 1'b1) begin tests_failed++; $display("FAIL read_critical_on got=%b exp=1", critical); end
    send(1'b0, 8'h12);
    send(1'b0, 8'h34);
    send(1'b0, 8'h56);
    tests_run++; if (sd_addr !== 25'h0123456) begin tests_failed++; $display("FAIL read_addr got=%h exp=%h", sd_addr, 25'h0123456); end
    tests_run++; if (sd_enable !== 1'b1) begin tests_failed++; $display("FAIL read_enable_latency got=%b exp=1", sd_enable); end
    for (int i = 0; i < 3; i++) begin
      repeat (6) begin
        @(negedge clk);
        if (critical !== 1'b1) crit_low++;
      end
      tests_run++; if (tx_data !== exp_tx[i]) begin tests_failed++; $display("FAIL read_data%0d tx_data=%h exp=%h", i, tx_data, exp_tx[i]); end
      send(1'b0, 8'h00);
    end
    tests_run++; if (crit_low !== 0) begin tests_failed++; $display("FAIL read_critical_held low_cycles=%0d exp=0", crit_low); end
    tests_run++;
    if (en_q.size() < base + 3) begin
      tests_failed++; $display("FAIL read_issue_count got=%0d exp>=3", en_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (en_q[base + i] !== exp_addr[i]) begin
          tests_failed++; $display("FAIL read_issue_addr%0d got=%h exp=%h", i, en_q[base + i], exp_addr[i]);
        end
      end
    end
    deselect(1);
    tests_run++; if (critical !== 1'b0) begin tests_failed++; $display("FAIL read_critical_off got=%b exp=0", critical); end
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL read_tx_deselect got=%h exp=FF", tx_data); end
    repeat (8) @(negedge clk);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL read_late_data got=%h exp=FF", tx_data); end
  endtask

  task automatic test_fast_read_wrap;
    int base;
    base = en_q.size();
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h0B);
    send(1'b0, 8'hFF);
    send(1'b0, 8'hFF);
    send(1'b0, 8'hFF);
    tests_run++; if (sd_addr !== 25'h0FFFFFF) begin tests_failed++; $display("FAIL fast_addr got=%h exp=%h", sd_addr, 25'h0FFFFFF); end
    repeat (6) @(negedge clk);
    tests_run++; if (tx_data !== 8'h10) begin tests_failed++; $display("FAIL fast_data0 tx_data=%h exp=10", tx_data); end
    send(1'b0, 8'h00);
    tests_run++; if (sd_addr !== 25'h0FFFFFF) begin tests_failed++; $display("FAIL fast_dummy_addr got=%h exp=%h", sd_addr, 25'h0FFFFFF); end
    repeat (2) @(negedge clk);
    tests_run++; if (en_q.size() !== base + 1) begin tests_failed++; $display("FAIL fast_dummy_noread issues=%0d exp=1", en_q.size() - base); end
    send(1'b0, 8'h00);
    tests_run++; if (sd_addr !== 25'h0000000) begin tests_failed++; $display("FAIL fast_wrap got=%h exp=0000000", sd_addr); end
    repeat (6) @(negedge clk);
    tests_run++; if (tx_data !== 8'h11) begin tests_failed++; $display("FAIL fast_data1 tx_data=%h exp=11", tx_data); end
    send(1'b0, 8'h00);
    tests_run++; if (sd_addr !== 25'h0000001) begin tests_failed++; $display("FAIL fast_incr got=%h exp=0000001", sd_addr); end
    deselect(8);
    tests_run++;
    if (en_q.size() < base + 2) begin
      tests_failed++; $display("FAIL fast_issue_count got=%0d exp>=2", en_q.size() - base);
    end else if (en_q[base] !== 25'h0FFFFFF || en_q[base + 1] !== 25'h0000000) begin
      tests_failed++; $display("FAIL fast_issue_order got=%h,%h exp=0FFFFFF,0000000", en_q[base], en_q[base + 1]);
    end
  endtask

  task automatic test_rdid;
    int base;
    logic [7:0] exp_id [4];
    exp_id = '{8'hEF, 8'h40, 8'h18, 8'h00};
    base = en_q.size();
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send((i == 0), 8'h9F);
      tests_run++; if (tx_data !== exp_id[i]) begin tests_failed++; $display("FAIL rdid_byte%0d tx_data=%h exp=%h", i, tx_data, exp_id[i]); end
    end
    repeat (2) @(negedge clk);
    tests_run++; if (en_q.size() !== base) begin tests_failed++; $display("FAIL rdid_no_read issues=%0d exp=0", en_q.size() - base); end
    deselect(2);
  endtask

  task automatic test_status_ignore;
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h05);
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rdsr_first tx_data=%h exp=00", tx_data); end
    send(1'b0, 8'hAA);
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rdsr_repeat tx_data=%h exp=00", tx_data); end
    deselect(2);
    cs_n = 1'b0;
    send(1'b1, 8'h42);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL ignore_tx tx_data=%h exp=FF", tx_data); end
    tests_run++; if (critical !== 1'b1) begin tests_failed++; $display("FAIL ignore_critical got=%b exp=1", critical); end
    deselect(2);
  endtask

  task automatic test_busy;
    int base;
    int drop_cyc;
    base = en_q.size();
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'h01);
    sd_busy = 1'b1;
    send(1'b0, 8'h00);
    tests_run++; if (sd_enable !== 1'b0) begin tests_failed++; $display("FAIL busy_hold got=%b exp=0", sd_enable); end
    repeat (8) @(negedge clk);
    sd_busy = 1'b0;
    drop_cyc = cyc;
    repeat (3) @(negedge clk);
    tests_run++;
    if (en_q.size() !== base + 1) begin
      tests_failed++; $display("FAIL busy_issue_count got=%0d exp=1", en_q.size() - base);
    end else if (en_cyc_q[base] !== drop_cyc + 1 || en_q[base] !== 25'h0000100) begin
      tests_failed++; $display("FAIL busy_issue_when cyc=%0d addr=%h exp cyc=%0d addr=0000100", en_cyc_q[base], en_q[base], drop_cyc + 1);
    end
    deselect(8);
  endtask

  task automatic test_cs_pending;
    int base;
    model_quiet = 1'b1;
    sd_rd_ready = 1'b0;
    base = en_q.size();
    @(negedge clk);
    cs_n = 1'b0;
    sd_busy = 1'b1;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'h02);
    send(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    sd_busy = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (en_q.size() !== base) begin tests_failed++; $display("FAIL cs_pending_issued issues=%0d exp=0", en_q.size() - base); end
    sd_rd_ready = 1'b1;
    sd_rd_data  = 8'h77;
    @(negedge clk);
    sd_rd_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL cs_late_ready tx_data=%h exp=FF", tx_data); end
    model_quiet = 1'b0;
  endtask

  task automatic test_simultaneous;
    model_quiet = 1'b1;
    sd_rd_ready = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    send(1'b0, 8'h10);
    repeat (2) @(negedge clk);
    rx_strobe   = 1'b1;
    rx_cmd      = 1'b0;
    rx_data     = 8'h00;
    sd_rd_ready = 1'b1;
    sd_rd_data  = 8'h3C;
    @(negedge clk);
    rx_strobe   = 1'b0;
    sd_rd_ready = 1'b0;
    tests_run++; if (sd_addr !== 25'h0000011) begin tests_failed++; $display("FAIL simul_addr got=%h exp=0000011", sd_addr); end
    tests_run++; if (tx_data !== 8'h3C) begin tests_failed++; $display("FAIL simul_data tx_data=%h exp=3C", tx_data); end
    deselect(8);
    model_quiet = 1'b0;
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    send(1'b0, 8'h20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (critical !== 1'b0 || tx_data !== 8'hFF || sd_addr !== 25'h0 || sd_enable !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_values crit=%b tx=%h addr=%h en=%b exp 0/FF/0/0", critical, tx_data, sd_addr, sd_enable);
    end
    repeat (6) @(negedge clk);
    send(1'b0, 8'h55);
    tests_run++; if (critical !== 1'b0 || tx_data !== 8'hFF) begin
      tests_failed++; $display("FAIL midreset_needs_cmd crit=%b tx=%h exp 0/FF", critical, tx_data);
    end
    send(1'b1, 8'h9F);
    tests_run++; if (tx_data !== 8'hEF || critical !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_new_cmd tx=%h crit=%b exp EF/1", tx_data, critical);
    end
    deselect(4);
  endtask

`ifdef SPI_RESPONDER_LOG_EN
  task automatic test_log;
    logic [7:0] exp_log [4];
    exp_log = '{8'h03, 8'h00, 8'hAB, 8'hCD};
    log_ready = 1'b1;
    log_q.delete();
    @(negedge clk);
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'hAB);
    send(1'b0, 8'hCD);
    repeat (8) @(negedge clk);
    deselect(8);
    tests_run++;
    if (log_q.size() !== 4) begin
      tests_failed++; $display("FAIL log_record_len got=%0d exp=4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (log_q[i] !== exp_log[i]) begin
          tests_failed++; $display("FAIL log_byte%0d got=%h exp=%h", i, log_q[i], exp_log[i]);
        end
      end
    end
    log_q.delete();
    log_ready = 1'b0;
    cs_n = 1'b0;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'hAB);
    send(1'b0, 8'hCD);
    repeat (4) @(negedge clk);
    deselect(2);
    log_ready = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++; if (log_q.size() !== 0) begin tests_failed++; $display("FAIL log_dropped got=%0d bytes exp=0", log_q.size()); end
  endtask
`else
  task automatic test_log;
    tests_run++; if (log_q.size() !== 0) begin tests_failed++; $display("FAIL log_tied_strobe bytes=%0d exp=0", log_q.size()); end
    tests_run++; if (log_data !== 8'h00) begin tests_failed++; $display("FAIL log_tied_data got=%h exp=00", log_data); end
  endtask
`endif

  task automatic test_enable_rules;
    tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL enable_rules violations=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_fast_read_wrap;
    test_rdid;
    test_status_ignore;
    test_busy;
    test_cs_pending;
    test_simultaneous;
    test_mid_reset;
    test_log;
    test_enable_rules;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
